rs_encode_stream_out_ctrl: RTL and testbench
============================================

Name: rs_encode_stream_out_ctrl

Overview:
Output stage directly downstream of the RS encode input controller and the RS unit array. Accepts per-request metadata (block count) from the input controller, emits one response header, then drains encoded blocks from the RS units in strict round-robin order (unit 0, 1, …, wrapping). Each block is data lines followed by parity lines, forwarded as a single output stream with a last-line flag.

Parameters:
NUM_RS_UNITS, 4, number of RS encode units; must be ≥1.
NUM_RS_UNITS_W, $clog2(NUM_RS_UNITS) (min 1), unit select width.
DATA_W, 256, line width in bits.
BLOCK_LINES, 8, total lines per encoded block (data + parity); ≥2.
BLOCK_CNT_W, 16, width of block count metadata.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_ctrl_out_ctrl_val  in  1  metadata valid from input controller
out_ctrl_in_ctrl_rdy  out  1  metadata accept
in_ctrl_out_ctrl_num_blocks  in  BLOCK_CNT_W  blocks in this request
rs_unit_out_ctrl_val  in  NUM_RS_UNITS  per-unit line valid
rs_unit_out_ctrl_data  in  NUM_RS_UNITS*DATA_W  per-unit line data, unit i at [i*DATA_W +: DATA_W]
out_ctrl_rs_unit_rdy  out  NUM_RS_UNITS  per-unit line accept (one-hot or zero)
stream_encoder_dst_hdr_val  out  1  response header valid
stream_encoder_dst_hdr_num_blocks  out  BLOCK_CNT_W  header payload
dst_stream_encoder_hdr_rdy  in  1  header accept
stream_encoder_dst_data_val  out  1  output line valid
stream_encoder_dst_data  out  DATA_W  output line
stream_encoder_dst_data_last  out  1  final line of request
dst_stream_encoder_data_rdy  in  1  output line accept

Behaviour:
- Reset (rst_n low, async): state READY, unit_sel=0, line_cnt=0, block_cnt=0, num_blocks_reg=0. Outputs: out_ctrl_in_ctrl_rdy=1 (combinational from READY), all other vals/rdys 0, data/hdr buses 0. Reset mid-request abandons the request; no partial flush.
- Handshake: transfer when val & rdy in same cycle. val never depends on rdy of the same interface. Data/header held stable while val & !rdy.
- States:
  READY: out_ctrl_in_ctrl_rdy=1; on val: latch num_blocks, unit_sel←0, line_cnt←0, block_cnt←0, → SEND_HDR.
  SEND_HDR: hdr_val=1, payload=num_blocks_reg. On hdr_rdy: num_blocks_reg==0 → READY; else → STREAM.
  STREAM: combinational pass-through from unit_sel: data_val = rs_unit_out_ctrl_val[unit_sel]; out_ctrl_rs_unit_rdy[unit_sel] = data_rdy, other bits 0; data = unit_sel slice. On transfer: line_cnt+1; at line_cnt==BLOCK_LINES-1: line_cnt←0, block_cnt+1, unit_sel wraps NUM_RS_UNITS-1→0; if block_cnt==num_blocks_reg-1 → READY, else stay.
  data_last = 1 only on line_cnt==BLOCK_LINES-1 && block_cnt==num_blocks_reg-1.
- Zero added latency in STREAM (combinational mux). Header precedes any data of that request; next request's metadata is accepted only in READY (no overlap).
- Valid from non-selected units ignored; they stall until selected.
- Counters: line_cnt $clog2(BLOCK_LINES) bits, block_cnt BLOCK_CNT_W bits; max num_blocks 2^BLOCK_CNT_W-1 supported without overflow.

Optional Feature:
RS_OUT_CTRL_STATS_EN: when defined, adds outputs stat_req_cnt (32b) and stat_line_cnt (32b), counting completed header transfers and output line transfers respectively; saturate at all-ones; cleared by reset only. When undefined, ports and logic are absent; behaviour otherwise identical.

Test Plan:
- num_blocks=3, NUM_RS_UNITS=4, all rdy=1 → header(3), 24 lines from units 0,1,2 in order, last asserted only on line 24, back to READY.
- num_blocks=5, NUM_RS_UNITS=4 → blocks from units 0,1,2,3,0; unit 0 rdy asserted for lines 1–8 and 33–40 only.
- num_blocks=0 → header(0) accepted, no data lines, no unit rdy ever asserted, READY next cycle.
- Random dst_data_rdy/unit val stalls, num_blocks=2 → output sequence identical to unstalled run; data stable across every stall cycle.
- Metadata val asserted during STREAM → out_ctrl_in_ctrl_rdy=0 until READY; accepted the cycle after last line transfers.
- rst_n pulsed low mid-block 1 → all vals 0 immediately, READY after release, next request starts at unit 0 with header.

Source files
------------

// File: rtl/rs_encode_stream_out_ctrl.sv
// RS encode output controller: accepts per-request block count, emits one
// response header, then drains BLOCK_LINES-line blocks from the RS units in
// strict round-robin order as a single stream with a last-line flag.
// Optional build macro: RS_OUT_CTRL_STATS_EN adds saturating request/line
// statistics counters (stat_req_cnt, stat_line_cnt).
module rs_encode_stream_out_ctrl #(
  parameter int unsigned NUM_RS_UNITS   = 4,
  parameter int unsigned NUM_RS_UNITS_W = (NUM_RS_UNITS > 1) ? $clog2(NUM_RS_UNITS) : 1,
  parameter int unsigned DATA_W         = 256,
  parameter int unsigned BLOCK_LINES    = 8,
  parameter int unsigned BLOCK_CNT_W    = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_ctrl_out_ctrl_val,
  output logic                           out_ctrl_in_ctrl_rdy,
  input  logic [BLOCK_CNT_W-1:0]         in_ctrl_out_ctrl_num_blocks,
  input  logic [NUM_RS_UNITS-1:0]        rs_unit_out_ctrl_val,
  input  logic [NUM_RS_UNITS*DATA_W-1:0] rs_unit_out_ctrl_data,
  output logic [NUM_RS_UNITS-1:0]        out_ctrl_rs_unit_rdy,
  output logic                           stream_encoder_dst_hdr_val,
  output logic [BLOCK_CNT_W-1:0]         stream_encoder_dst_hdr_num_blocks,
  input  logic                           dst_stream_encoder_hdr_rdy,
  output logic                           stream_encoder_dst_data_val,
  output logic [DATA_W-1:0]              stream_encoder_dst_data,
  output logic                           stream_encoder_dst_data_last,
  input  logic                           dst_stream_encoder_data_rdy
`ifdef RS_OUT_CTRL_STATS_EN
  ,
  output logic [31:0]                    stat_req_cnt,
  output logic [31:0]                    stat_line_cnt
`endif
);

  localparam int unsigned LINE_CNT_W = $clog2(BLOCK_LINES);
  localparam logic [LINE_CNT_W-1:0]     LAST_LINE = LINE_CNT_W'(BLOCK_LINES - 1);
  localparam logic [NUM_RS_UNITS_W-1:0] LAST_UNIT = NUM_RS_UNITS_W'(NUM_RS_UNITS - 1);

  typedef enum logic [1:0] {
    ST_READY,
    ST_SEND_HDR,
    ST_STREAM
  } state_t;

  state_t                    r_state;
  logic [NUM_RS_UNITS_W-1:0] r_unit_sel;
  logic [LINE_CNT_W-1:0]     r_line_cnt;
  logic [BLOCK_CNT_W-1:0]    r_block_cnt;
  logic [BLOCK_CNT_W-1:0]    r_num_blocks;

  logic [NUM_RS_UNITS-1:0][DATA_W-1:0] w_unit_data;
  logic                                w_hdr_xfer;
  logic                                w_line_xfer;
  logic                                w_last_line;
  logic                                w_last_block;

  assign w_unit_data = rs_unit_out_ctrl_data;

  // Handshake decode and zero-latency pass-through from the selected unit
  always_comb begin
    w_last_line                       = (r_line_cnt == LAST_LINE);
    w_last_block                      = (r_block_cnt == (r_num_blocks - BLOCK_CNT_W'(1)));
    out_ctrl_in_ctrl_rdy              = (r_state == ST_READY);
    stream_encoder_dst_hdr_val        = (r_state == ST_SEND_HDR);
    stream_encoder_dst_hdr_num_blocks = '0;
    stream_encoder_dst_data_val       = 1'b0;
    stream_encoder_dst_data           = '0;
    stream_encoder_dst_data_last      = 1'b0;
    out_ctrl_rs_unit_rdy              = '0;
    if (r_state == ST_SEND_HDR) begin
      stream_encoder_dst_hdr_num_blocks = r_num_blocks;
    end
    if (r_state == ST_STREAM) begin
      stream_encoder_dst_data_val      = rs_unit_out_ctrl_val[r_unit_sel];
      stream_encoder_dst_data          = w_unit_data[r_unit_sel];
      stream_encoder_dst_data_last     = w_last_line && w_last_block;
      out_ctrl_rs_unit_rdy[r_unit_sel] = dst_stream_encoder_data_rdy;
    end
    w_hdr_xfer  = stream_encoder_dst_hdr_val && dst_stream_encoder_hdr_rdy;
    w_line_xfer = stream_encoder_dst_data_val && dst_stream_encoder_data_rdy;
  end

  // Request sequencing: metadata accept, header, round-robin block drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_READY;
      r_unit_sel   <= '0;
      r_line_cnt   <= '0;
      r_block_cnt  <= '0;
      r_num_blocks <= '0;
    end else begin
      case (r_state)
        ST_READY: begin
          if (in_ctrl_out_ctrl_val) begin
            r_num_blocks <= in_ctrl_out_ctrl_num_blocks;
            r_unit_sel   <= '0;
            r_line_cnt   <= '0;
            r_block_cnt  <= '0;
            r_state      <= ST_SEND_HDR;
          end
        end
        ST_SEND_HDR: begin
          if (w_hdr_xfer) begin
            r_state <= (r_num_blocks == '0) ? ST_READY : ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_line_xfer) begin
            if (w_last_line) begin
              r_line_cnt  <= '0;
              r_block_cnt <= r_block_cnt + BLOCK_CNT_W'(1);
              r_unit_sel  <= (r_unit_sel == LAST_UNIT) ? '0 : r_unit_sel + NUM_RS_UNITS_W'(1);
              if (w_last_block) begin
                r_state <= ST_READY;
              end
            end else begin
              r_line_cnt <= r_line_cnt + LINE_CNT_W'(1);
            end
          end
        end
        default: r_state <= ST_READY;
      endcase
    end
  end

`ifdef RS_OUT_CTRL_STATS_EN
  // Saturating counters of completed header and line transfers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_req_cnt  <= '0;
      stat_line_cnt <= '0;
    end else begin
      if (w_hdr_xfer && (stat_req_cnt != '1)) begin
        stat_req_cnt <= stat_req_cnt + 32'd1;
      end
      if (w_line_xfer && (stat_line_cnt != '1)) begin
        stat_line_cnt <= stat_line_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rs_encode_stream_out_ctrl.sv
// Self-checking bench for rs_encode_stream_out_ctrl: table of requests plus
// hand-written reset/back-to-back sequences, checked against a queue-based
// model of the expected output stream.
module tb_rs_encode_stream_out_ctrl;

  localparam int unsigned NU = 4;
  localparam int unsigned DW = 256;
  localparam int unsigned BL = 8;
  localparam int unsigned CW = 16;

  logic             clk;
  logic             rst_n;
  logic             meta_val;
  logic             meta_rdy;
  logic [CW-1:0]    meta_n;
  logic [NU-1:0]    u_val;
  logic [NU*DW-1:0] u_data;
  logic [NU-1:0]    u_rdy;
  logic             hdr_val;
  logic [CW-1:0]    hdr_n;
  logic             hdr_rdy;
  logic             d_val;
  logic [DW-1:0]    d;
  logic             d_last;
  logic             d_rdy;
`ifdef RS_OUT_CTRL_STATS_EN
  logic [31:0]      stat_req;
  logic [31:0]      stat_line;
`endif

  rs_encode_stream_out_ctrl #(
    .NUM_RS_UNITS(NU),
    .DATA_W      (DW),
    .BLOCK_LINES (BL),
    .BLOCK_CNT_W (CW)
  ) dut (
    .clk                              (clk),
    .rst_n                            (rst_n),
    .in_ctrl_out_ctrl_val             (meta_val),
    .out_ctrl_in_ctrl_rdy             (meta_rdy),
    .in_ctrl_out_ctrl_num_blocks      (meta_n),
    .rs_unit_out_ctrl_val             (u_val),
    .rs_unit_out_ctrl_data            (u_data),
    .out_ctrl_rs_unit_rdy             (u_rdy),
    .stream_encoder_dst_hdr_val       (hdr_val),
    .stream_encoder_dst_hdr_num_blocks(hdr_n),
    .dst_stream_encoder_hdr_rdy       (hdr_rdy),
    .stream_encoder_dst_data_val      (d_val),
    .stream_encoder_dst_data          (d),
    .stream_encoder_dst_data_last     (d_last),
    .dst_stream_encoder_data_rdy      (d_rdy)
`ifdef RS_OUT_CTRL_STATS_EN
    ,
    .stat_req_cnt                     (stat_req),
    .stat_line_cnt                    (stat_line)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned ucnt[NU];   // lines each unit has delivered so far
  bit          acc[NU];    // unit line accepted in the last sampled cycle

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Contents of the k-th line produced by unit u
  function automatic logic [DW-1:0] line_data(input int unsigned u, input int unsigned k);
    logic [DW-1:0] v;
    for (int unsigned i = 0; i < DW / 32; i++) begin
      v[i*32 +: 32] = (u << 28) ^ (k << 12) ^ (i * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    end
    return v;
  endfunction

  // Units hold val until accepted; otherwise val is random (stall) or always 1
  task automatic drive_units(input bit stall);
    for (int unsigned u = 0; u < NU; u++) begin
      if (!(u_val[u] && !acc[u])) begin
        u_val[u] = stall ? ($urandom_range(0, 99) < 60) : 1'b1;
      end
      u_data[u*DW +: DW] = line_data(u, ucnt[u]);
      acc[u] = 1'b0;
    end
  endtask

  // Run one request. busy: keep new metadata pending throughout (it should be
  // accepted right after the last line). pre: metadata already accepted.
  // abort_after: stop monitoring after that many lines (0 = run to end).
  task automatic run_req(input int unsigned n, input bit stall, input bit busy,
                         input bit pre, input int unsigned abort_after,
                         output int unsigned nlines);
    logic [DW-1:0] q_data[$];
    int unsigned   q_unit[$];
    bit            q_last[$];
    int unsigned   tc[NU];
    int unsigned   phase;  // 0 meta, 1 header, 2 data, 3 done
    int unsigned   idx;
    int unsigned   cyc;
    int unsigned   eu;
    bit            hold;
    bit            aborted;
    logic [DW-1:0] hold_data;

    for (int unsigned u = 0; u < NU; u++) tc[u] = ucnt[u];
    for (int unsigned b = 0; b < n; b++) begin
      for (int unsigned l = 0; l < BL; l++) begin
        q_data.push_back(line_data(b % NU, tc[b % NU]));
        q_unit.push_back(b % NU);
        q_last.push_back((b == n - 1) && (l == BL - 1));
        tc[b % NU]++;
      end
    end

    phase = pre ? 1 : 0;
    idx = 0; cyc = 0; hold = 0; aborted = 0; hold_data = '0;
    while (phase != 3 && cyc < 3000 && !aborted) begin
      @(negedge clk);
      cyc++;
      if (phase == 0) begin
        meta_val = 1'b1; meta_n = CW'(n);
      end else if (busy) begin
        meta_val = 1'b1; meta_n = CW'(1);
      end else begin
        meta_val = 1'b0;
      end
      hdr_rdy = stall ? ($urandom_range(0, 99) < 60) : 1'b1;
      d_rdy   = stall ? ($urandom_range(0, 99) < 60) : 1'b1;
      drive_units(stall);
      #1;
      eu = (idx < q_unit.size()) ? q_unit[idx] : 0;
      chk("hdr_val", DW'(hdr_val), DW'(phase == 1));
      if (phase == 1) chk("hdr_num_blocks", DW'(hdr_n), DW'(n));
      if (busy && (phase == 1 || phase == 2)) chk("meta_rdy_busy", DW'(meta_rdy), '0);
      if (phase == 2) begin
        chk("data_val", DW'(d_val), DW'(u_val[eu]));
        chk("unit_rdy", DW'(u_rdy), d_rdy ? DW'(1 << eu) : '0);
        if (d_val) begin
          if (hold) chk("data_stable", d, hold_data);
          if (d_rdy) begin
            chk("data", d, q_data[idx]);
            chk("data_last", DW'(d_last), DW'(q_last[idx]));
            ucnt[eu]++;
            acc[eu] = 1'b1;
            idx++;
            hold = 0;
            if (idx == q_data.size()) phase = 3;
            if (abort_after != 0 && idx == abort_after) aborted = 1;
          end else begin
            hold = 1;
            hold_data = d;
          end
        end
      end else begin
        chk("data_val_idle", DW'(d_val), '0);
        chk("unit_rdy_idle", DW'(u_rdy), '0);
      end
      if (phase == 1 && hdr_rdy) phase = (n == 0) ? 3 : 2;
      if (phase == 0 && meta_rdy) phase = 1;
    end
    nlines = idx;
    if (!aborted) begin
      chk("request_done", DW'(phase), DW'(3));
      @(negedge clk);
      meta_val = busy;
      meta_n   = CW'(1);
      d_rdy    = 1'b1;
      hdr_rdy  = 1'b1;
      drive_units(stall);
      #1;
      chk("meta_rdy_after", DW'(meta_rdy), DW'(1));
      chk("hdr_val_after", DW'(hdr_val), '0);
      chk("data_val_after", DW'(d_val), '0);
    end
  endtask

  typedef struct {
    int unsigned n;
    bit          stall;
    bit          busy;
    bit          pre;
    int unsigned exp_lines;
  } vec_t;

  vec_t        tbl[7];
  int unsigned nl;
  int unsigned rn;

  initial begin
    tbl[0] = '{n: 3, stall: 0, busy: 0, pre: 0, exp_lines: 24};
    tbl[1] = '{n: 5, stall: 0, busy: 0, pre: 0, exp_lines: 40};
    tbl[2] = '{n: 0, stall: 0, busy: 0, pre: 0, exp_lines: 0};
    tbl[3] = '{n: 2, stall: 1, busy: 0, pre: 0, exp_lines: 16};
    tbl[4] = '{n: 2, stall: 0, busy: 1, pre: 0, exp_lines: 16};
    tbl[5] = '{n: 1, stall: 0, busy: 0, pre: 1, exp_lines: 8};
    tbl[6] = '{n: 4, stall: 1, busy: 0, pre: 0, exp_lines: 32};

    rst_n = 1'b0; meta_val = 1'b0; meta_n = '0; u_val = '0; u_data = '0;
    hdr_rdy = 1'b0; d_rdy = 1'b0;
    for (int unsigned u = 0; u < NU; u++) begin ucnt[u] = 0; acc[u] = 0; end
    #1;
    chk("rst_meta_rdy", DW'(meta_rdy), DW'(1));
    chk("rst_hdr_val", DW'(hdr_val), '0);
    chk("rst_hdr_bus", DW'(hdr_n), '0);
    chk("rst_data_val", DW'(d_val), '0);
    chk("rst_data_bus", d, '0);
    chk("rst_unit_rdy", DW'(u_rdy), '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 7; i++) begin
      run_req(tbl[i].n, tbl[i].stall, tbl[i].busy, tbl[i].pre, 0, nl);
      chk("line_count", DW'(nl), DW'(tbl[i].exp_lines));
    end

    for (int unsigned i = 0; i < 4; i++) begin
      rn = $urandom_range(0, 6);
      run_req(rn, 1, 0, 0, 0, nl);
      chk("rand_line_count", DW'(nl), DW'(rn * BL));
    end

    // Reset in the middle of block 1 abandons the request
    run_req(3, 0, 0, 0, BL + 3, nl);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_hdr_val", DW'(hdr_val), '0);
    chk("midrst_data_val", DW'(d_val), '0);
    chk("midrst_unit_rdy", DW'(u_rdy), '0);
    chk("midrst_meta_rdy", DW'(meta_rdy), DW'(1));
    u_val = '0; meta_val = 1'b0;
    for (int unsigned u = 0; u < NU; u++) begin ucnt[u] = 0; acc[u] = 0; end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_req(2, 0, 0, 0, 0, nl);
    chk("post_rst_line_count", DW'(nl), DW'(2 * BL));

    @(negedge clk);
    meta_val = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
